// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, FSM encoding and width helper for the FPU arbiter
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpu_arbiter_if.sv
// rtl/fpu_arbiter_if.sv - request, response and FPU-side signal bundle of the FPU arbiter
interface fpu_arbiter_if
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_overflow;
  logic                  rsp_underflow;

  logic [31:0]           fpu_op1;
  logic [31:0]           fpu_op2;
  logic [1:0]            fpu_operation;
  logic [31:0]           fpu_result;
  logic                  fpu_overflow;
  logic                  fpu_underflow;

  modport master (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    input  fpu_result, fpu_overflow, fpu_underflow,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow,
    output fpu_op1, fpu_op2, fpu_operation
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    output fpu_result, fpu_overflow, fpu_underflow,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow,
    input  fpu_op1, fpu_op2, fpu_operation
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first valid index at or after ptr, with wrap
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one external combinational FPU among NUM_REQ requesters
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int LAT_FAST = 1,
  parameter int LAT_DIV  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  fpu_arbiter_if.master bus
);

  localparam int LAT_MAX = (LAT_DIV > LAT_FAST) ? LAT_DIV : LAT_FAST;
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  logic [1:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic [CNT_W-1:0]   sel_cnt;
  logic [ID_W-1:0]    ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // The accept pulse is only meaningful in IDLE and is forced low while reset is held.
  assign bus.req_ready = (rst_n && state == ST_IDLE) ? grant : '0;

  always_comb begin
    int sel;
    sel      = int'(gnt_idx);
    sel_op   = bus.req_op[2*sel +: 2];
    sel_a    = bus.req_a[32*sel +: 32];
    sel_b    = bus.req_b[32*sel +: 32];
    sel_cnt  = (sel_op == OP_DIV) ? CNT_W'(LAT_DIV - 1) : CNT_W'(LAT_FAST - 1);
    ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      cnt               <= '0;
      busy              <= 1'b0;
      bus.fpu_op1       <= '0;
      bus.fpu_op2       <= '0;
      bus.fpu_operation <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_result    <= '0;
      bus.rsp_overflow  <= 1'b0;
      bus.rsp_underflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            bus.fpu_op1       <= sel_a;
            bus.fpu_op2       <= sel_b;
            bus.fpu_operation <= sel_op;
            bus.rsp_id        <= gnt_idx;
            cnt               <= sel_cnt;
            ptr               <= ptr_next;
            busy              <= 1'b1;
            state             <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // FPU inputs stay untouched here so the combinational core settles for the full budget.
          if (cnt == '0) begin
            bus.rsp_result    <= bus.fpu_result;
            bus.rsp_overflow  <= bus.fpu_overflow;
            bus.rsp_underflow <= bus.fpu_underflow;
            bus.rsp_valid     <= 1'b1;
            state             <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - scoreboard bench for fpu_arbiter with a table-driven FPU core
module tb_fpu_arbiter;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  logic [3:0]   v_valid = '0;
  logic [7:0]   v_op = '0;
  logic [127:0] v_a = '0;
  logic [127:0] v_b = '0;
  logic         v_rsp_ready = 1'b1;
  logic [31:0]  f_res;
  logic         f_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  logic prev_rv = 1'b0;
  logic [3:0] acc = '0;

  req_t req_q[4][$];
  int   grant_q[$];
  exp_t rsp_q[$];
  exp_t mon_e;
  int   mon_g;
  req_t drv_tmp;

  fpu_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  assign bus.req_valid     = v_valid;
  assign bus.req_op        = v_op;
  assign bus.req_a         = v_a;
  assign bus.req_b         = v_b;
  assign bus.rsp_ready     = v_rsp_ready;
  assign bus.fpu_result    = f_res;
  assign bus.fpu_overflow  = f_ovf;
  assign bus.fpu_underflow = 1'b0;

  fpu_arbiter #(.NUM_REQ(4), .ID_W(2), .LAT_FAST(1), .LAT_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational FPU core covering exactly the operand pairs used below.
  always_comb begin
    f_res = 32'h0;
    f_ovf = 1'b0;
    case ({bus.fpu_operation, bus.fpu_op1, bus.fpu_op2})
      {2'd0, 32'h3F800000, 32'h40000000}: f_res = 32'h40400000;
      {2'd1, 32'h40400000, 32'h3F800000}: f_res = 32'h40000000;
      {2'd2, 32'h40000000, 32'h40400000}: f_res = 32'h40C00000;
      {2'd3, 32'h41200000, 32'h40000000}: f_res = 32'h40A00000;
      {2'd2, 32'h3F800000, 32'h40000000}: f_res = 32'h40000000;
      {2'd2, 32'h7F000000, 32'h7F000000}: begin f_res = 32'h7F800000; f_ovf = 1'b1; end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic ovf, input int lat, input bit want_rsp);
    req_t r;
    exp_t e;
    r.op = op; r.a = a; r.b = b;
    req_q[i].push_back(r);
    grant_q.push_back(i);
    if (want_rsp) begin
      e.id = i; e.res = res; e.ovf = ovf; e.lat = lat;
      rsp_q.push_back(e);
    end
  endtask

  function automatic bit all_empty();
    return rsp_q.size() == 0 && grant_q.size() == 0 && req_q[0].size() == 0 &&
           req_q[1].size() == 0 && req_q[2].size() == 0 && req_q[3].size() == 0;
  endfunction

  task automatic drain(input string nm);
    bit done = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (all_empty() && !busy && !bus.rsp_valid) begin
        done = 1;
        break;
      end
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fpu_op1"}, bus.fpu_op1, 32'h0);
    chk({tag, "_fpu_op2"}, bus.fpu_op2, 32'h0);
    chk({tag, "_fpu_operation"}, 32'(bus.fpu_operation), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'h0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 32'h0);
    chk({tag, "_rsp_flags"}, {30'h0, bus.rsp_overflow, bus.rsp_underflow}, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
  endtask

  // Drives queued requests; a request is retired right after the edge that accepted it.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        drv_tmp = req_q[i].pop_front();
        acc[i] = 1'b0;
        v_valid[i] = 1'b0;
      end
      if (!v_valid[i] && req_q[i].size() > 0) begin
        v_valid[i] = 1'b1;
        v_op[2*i +: 2] = req_q[i][0].op;
        v_a[32*i +: 32] = req_q[i][0].a;
        v_b[32*i +: 32] = req_q[i][0].b;
      end
    end
  end

  // Monitor: grants and responses are checked against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      acc = bus.req_ready & bus.req_valid;
      if (bus.req_ready != '0) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", 32'(bus.req_ready), 32'h0);
        end else begin
          mon_g = grant_q.pop_front();
          chk("grant", 32'(bus.req_ready), 32'(1) << mon_g);
        end
        chk("grant_while_busy", 32'(busy), 32'h0);
        last_acc = cyc + 1;
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
        end else begin
          mon_e = rsp_q[0];
          if (!prev_rv) chk("latency", 32'(cyc - last_acc), 32'(mon_e.lat));
          chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
          chk("rsp_result", bus.rsp_result, mon_e.res);
          chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(mon_e.ovf));
          chk("rsp_underflow", 32'(bus.rsp_underflow), 32'h0);
          if (bus.rsp_ready) mon_e = rsp_q.pop_front();
        end
      end
      prev_rv = bus.rsp_valid;
    end else begin
      acc = '0;
      prev_rv = 1'b0;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset in the middle of a DIV: no response may ever appear for it.
    send(2, 2'd3, 32'h41200000, 32'h40000000, 32'h0, 1'b0, 4, 1'b0);
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    chk("div_started", 32'(busy), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_exec");
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'h0);
    drain("drain_reset");

    send(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1, 1'b1);
    drain("drain_add");
    send(2, 2'd3, 32'h41200000, 32'h40000000, 32'h40A00000, 1'b0, 4, 1'b1);
    drain("drain_div");

    // Pointer now 3: a lone request at 1 must be found by wrapping, leaving the pointer at 2.
    send(1, 2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1, 1'b1);
    drain("drain_wrap");
    send(2, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1, 1'b1);
    send(3, 2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1, 1'b1);
    drain("drain_ptr2");

    send(0, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1, 1'b1);
    send(1, 2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1, 1'b1);
    send(2, 2'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1, 1'b1);
    send(3, 2'd3, 32'h41200000, 32'h40000000, 32'h40A00000, 1'b0, 4, 1'b1);
    send(0, 2'd2, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1, 1'b1);
    drain("drain_all4");

    // Overflowing MUL held under backpressure while another requester waits.
    v_rsp_ready = 1'b0;
    send(1, 2'd2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1, 1'b1);
    send(3, 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1, 1'b1);
    for (int k = 0; k < 20 && !bus.rsp_valid; k++) @(negedge clk);
    chk("mul_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("held_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("held_grants_pending", 32'(grant_q.size()), 32'd1);
    @(posedge clk); #1 v_rsp_ready = 1'b1;
    drain("drain_backpressure");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
